// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: mul/div handshake, direct writes, read stall and result outputs.
// master: the surrounding pipeline; slave: hilo_unit.
interface hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic                 abort;
  logic                 res_valid;
  logic [2*WIDTH-1:0]   res;
  logic                 mthi;
  logic                 mtlo;
  logic [WIDTH-1:0]     wdata;
  logic                 rd_req;
  logic [WIDTH-1:0]     hi_out;
  logic [WIDTH-1:0]     lo_out;
  logic                 busy;
  logic                 stall;
  logic                 err;

  modport master (
    output start, op, abort, res_valid, res, mthi, mtlo, wdata, rd_req,
    input  hi_out, lo_out, busy, stall, err
  );

  modport slave (
    input  start, op, abort, res_valid, res, mthi, mtlo, wdata, rd_req,
    output hi_out, lo_out, busy, stall, err
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO result register pair with a pending-operation scoreboard.
// Optional multiply-add/subtract accumulation is enabled by defining HILO_MADD_EN.
module hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  hilo_unit_if.slave bus
);

`ifdef HILO_MADD_EN
  typedef enum logic [1:0] {StIdle, StWait, StAcc} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait} state_e;
`endif

  state_e             state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               err_q;
  logic               idle;
  logic               op_ok;
  logic               wr_any;
  logic               proto_err;

`ifdef HILO_MADD_EN
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] acc_sum;
`endif

  assign idle   = (state_q == StIdle);
  assign wr_any = bus.mthi | bus.mtlo;

  // Decode which op codes this build accepts.
  always_comb begin
    op_ok = (bus.op == 2'b00);
`ifdef HILO_MADD_EN
    if (bus.op == 2'b01 || bus.op == 2'b10) op_ok = 1'b1;
`endif
  end

  // Any input that the current state cannot honour raises the sticky error.
  always_comb begin
    proto_err = 1'b0;
    if (idle && bus.start && (!op_ok || wr_any)) proto_err = 1'b1;
    if (!idle && (wr_any || bus.start))          proto_err = 1'b1;
    if (bus.res_valid && state_q != StWait)      proto_err = 1'b1;
  end

`ifdef HILO_MADD_EN
  // op 01 adds, op 10 subtracts; wraps modulo 2^(2*WIDTH).
  assign acc_sum = op_q[1] ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
`endif

  // FSM with registered HI/LO, busy and err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef HILO_MADD_EN
      op_q    <= 2'b00;
      prod_q  <= '0;
`endif
    end else begin
      if (proto_err) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (op_ok) begin
              state_q <= StWait;
              busy_q  <= 1'b1;
`ifdef HILO_MADD_EN
              op_q    <= bus.op;
`endif
            end
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        StWait: begin
          // abort beats a same-cycle result
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (bus.res_valid) begin
`ifdef HILO_MADD_EN
            if (op_q == 2'b00) begin
              {hi_q, lo_q} <= bus.res;
              state_q      <= StIdle;
              busy_q       <= 1'b0;
            end else begin
              prod_q  <= bus.res;
              state_q <= StAcc;
            end
`else
            {hi_q, lo_q} <= bus.res;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
`endif
          end
        end
`ifdef HILO_MADD_EN
        StAcc: begin
          if (!bus.abort) {hi_q, lo_q} <= acc_sum;
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
  assign bus.stall  = bus.rd_req & busy_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: directed scenarios followed by random traffic.
module tb_hilo_unit;
  localparam int unsigned W = 32;
`ifdef HILO_MADD_EN
  localparam bit Madd = 1'b1;
`else
  localparam bit Madd = 1'b0;
`endif

  typedef struct packed {
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic          abort;
    logic          res_valid;
    logic [63:0]   res;
    logic          mthi;
    logic          mtlo;
    logic [31:0]   wdata;
    logic          rd_req;
  } stim_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Reference model: HI:LO as one 64-bit number plus a pending-operation phase.
  logic [63:0] m_hilo;
  logic [63:0] m_prod;
  int          m_phase;  // 0 nothing pending, 1 waiting for result, 2 accumulating
  logic [1:0]  m_op;
  logic        m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input stim_t s);
    bit legal;
    legal = (s.op == 2'd0) || (Madd && (s.op == 2'd1 || s.op == 2'd2));
    if (s.rst) begin
      m_hilo = '0; m_phase = 0; m_err = 1'b0; m_op = 2'd0; m_prod = '0;
      return;
    end
    if (m_phase == 0) begin
      if (s.res_valid) m_err = 1'b1;
      if (s.start) begin
        if (s.mthi || s.mtlo || !legal) m_err = 1'b1;
        if (legal) begin m_phase = 1; m_op = s.op; end
      end else begin
        if (s.mthi) m_hilo[63:32] = s.wdata;
        if (s.mtlo) m_hilo[31:0]  = s.wdata;
      end
    end else begin
      if (s.start || s.mthi || s.mtlo) m_err = 1'b1;
      if (m_phase == 2 && s.res_valid) m_err = 1'b1;
      if (s.abort) m_phase = 0;
      else if (m_phase == 1) begin
        if (s.res_valid) begin
          if (m_op == 2'd0) begin m_hilo = s.res; m_phase = 0; end
          else begin m_prod = s.res; m_phase = 2; end
        end
      end else begin
        m_hilo  = (m_op == 2'd1) ? m_hilo + m_prod : m_hilo - m_prod;
        m_phase = 0;
      end
    end
  endtask

  // Drive one cycle: apply inputs after the edge, queue what the DUT should show now.
  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = s.rst;
    bus.start     = s.start;
    bus.op        = s.op;
    bus.abort     = s.abort;
    bus.res_valid = s.res_valid;
    bus.res       = s.res;
    bus.mthi      = s.mthi;
    bus.mtlo      = s.mtlo;
    bus.wdata     = s.wdata;
    bus.rd_req    = s.rd_req;
    e.hi    = m_hilo[63:32];
    e.lo    = m_hilo[31:0];
    e.busy  = (m_phase != 0);
    e.err   = m_err;
    e.stall = s.rd_req && (m_phase != 0);
    exp_q.push_back(e);
    model_edge(s);
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hi_out", {32'd0, bus.hi_out}, {32'd0, e.hi});
        chk("lo_out", {32'd0, bus.lo_out}, {32'd0, e.lo});
        chk("busy",   {63'd0, bus.busy},   {63'd0, e.busy});
        chk("stall",  {63'd0, bus.stall},  {63'd0, e.stall});
        chk("err",    {63'd0, bus.err},    {63'd0, e.err});
      end
    end
  end

  initial begin
    stim_t s;
    m_hilo = '0; m_prod = '0; m_phase = 0; m_op = 2'd0; m_err = 1'b0;
    rst = 1'b1;
    bus.start = 0; bus.op = 0; bus.abort = 0; bus.res_valid = 0; bus.res = '0;
    bus.mthi = 0; bus.mtlo = 0; bus.wdata = '0; bus.rd_req = 0;

    // Reset, then a plain load two cycles after start.
    s = nop(); s.rst = 1; step(s); step(s);
    step(nop());
    s = nop(); s.start = 1; s.op = 2'd0; step(s);
    s = nop(); s.rd_req = 1; step(s);
    s = nop(); s.res_valid = 1; s.res = 64'h12345678_9ABCDEF0; step(s);
    step(nop()); step(nop());

    // Direct writes, then multiply-add (rejected when accumulation is absent).
    s = nop(); s.mthi = 1; s.wdata = 32'hFFFFFFFF; step(s);
    s = nop(); s.mtlo = 1; s.wdata = 32'h00000001; step(s);
    s = nop(); s.start = 1; s.op = 2'd1; step(s);
    s = nop(); s.res_valid = 1; s.res = 64'h1; step(s);
    step(nop()); step(nop()); step(nop());

    // Multiply-subtract from zero wraps to all ones.
    s = nop(); s.rst = 1; step(s);
    s = nop(); s.start = 1; s.op = 2'd2; step(s);
    s = nop(); s.res_valid = 1; s.res = 64'h1; step(s);
    step(nop()); step(nop());

    // Abort and result in the same cycle: result dropped.
    s = nop(); s.rst = 1; step(s);
    s = nop(); s.mthi = 1; s.mtlo = 1; s.wdata = 32'hA5A5_0F0F; step(s);
    s = nop(); s.start = 1; step(s);
    s = nop(); s.rd_req = 1; step(s);
    s = nop(); s.abort = 1; s.res_valid = 1; s.res = 64'hDEAD_BEEF_CAFE_F00D; step(s);
    s = nop(); s.rd_req = 1; step(s);

    // Illegal writes/starts while busy, then reset mid-wait.
    s = nop(); s.start = 1; step(s);
    s = nop(); s.mthi = 1; s.wdata = 32'h1111_2222; step(s);
    s = nop(); s.start = 1; step(s);
    step(nop());
    s = nop(); s.rst = 1; step(s);
    step(nop());

    // Random traffic with occasional resets so err keeps toggling.
    for (int i = 0; i < 4000; i++) begin
      s = nop();
      s.rst       = ($urandom_range(99) < 2);
      s.start     = ($urandom_range(99) < 20);
      s.op        = ($urandom_range(99) < 50) ? 2'd0 : 2'($urandom_range(3));
      s.abort     = ($urandom_range(99) < 6);
      s.res_valid = ($urandom_range(99) < 30);
      s.res       = {$urandom, $urandom};
      s.mthi      = ($urandom_range(99) < 10);
      s.mtlo      = ($urandom_range(99) < 10);
      s.wdata     = $urandom;
      s.rd_req    = ($urandom_range(99) < 30);
      step(s);
    end

    step(nop());
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Parametrised HI/LO result register pair for the ALU datapath, successor to the fixed 32-bit HI/LO latch. It holds the double-width multiply/divide result and tracks a pending multicycle operation with a busy scoreboard. It accepts direct HI/LO writes and, optionally, accumulates products into HI:LO for multiply-add and multiply-subtract. It sits between the mul/div units and the register-file writeback mux.

## Interface
- WIDTH, 32, width of each half; HI:LO is 2*WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  mul/div unit accepted an operation this cycle.
- op  in  2  mode sampled with start: 00 load, 01 multiply-add, 10 multiply-subtract, 11 reserved.
- abort  in  1  cancel the pending operation (pipeline flush).
- res_valid  in  1  result strobe from the mul/div unit.
- res  in  2*WIDTH  result; the upper half goes to HI.
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  WIDTH  direct write data.
- rd_req  in  1  a consumer is reading HI or LO this cycle.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.
- busy  out  1  operation pending; high in WAIT and ACC.
- stall  out  1  combinational rd_req & busy.
- err  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, WAIT, ACC. ACC exists only with HILO_MADD_EN.
- Reset, sync: HI=0, LO=0, state=IDLE, err=0; busy=0 and stall=0 follow from that. Reset overrides every other input, including a pending operation.
- IDLE:
  - start with op=00 (or 01/10 when enabled): latch op, go to WAIT.
  - start with op=11: not accepted, err set, stay in IDLE.
- WAIT, res_valid:
  - op=00: HI:LO = res, go to IDLE.
  - op=01/10: capture res in the product register, go to ACC.
- ACC, one cycle:
  - op=01: HI:LO = HI:LO + product.
  - op=10: HI:LO = HI:LO − product.
  - Both wrap modulo 2^(2*WIDTH), with the carry/borrow out discarded. Then go to IDLE.
- abort in WAIT or ACC: go to IDLE, HI/LO unchanged, no err. Same-cycle abort and res_valid: abort wins and the result is dropped. abort in IDLE is a no-op.
- mthi/mtlo in IDLE with no start: the selected halves load wdata. Both asserted together load both halves.
- Error conditions, all setting err with the offending input ignored:
  - mthi/mtlo while busy.
  - mthi/mtlo in the same cycle as an accepted start (start still accepted).
  - start in WAIT or ACC.
  - res_valid in IDLE or ACC.
- Same-cycle start and res_valid in IDLE: start accepted, res_valid ignored, err set.
- err clears only on rst.

## Timing
- Load: commit at the res_valid edge. hi_out/lo_out show the new value and busy=0 in the following cycle.
- Accumulate: res_valid edge goes to ACC. The next edge commits. Result is visible 2 cycles after res_valid.
- busy rises the cycle after an accepted start. It falls the cycle after the commit or abort edge.
- Direct writes are visible the cycle after the mthi/mtlo edge.
- stall is combinational, with no added latency. Outputs are registered; there is no read bypass.

## Configuration
- HILO_MADD_EN defined: ACC state and a 2*WIDTH-bit adder/subtractor are present; op 01/10 are legal.
- HILO_MADD_EN undefined: ACC and the adder are removed. op 01/10 are treated like 11: start not accepted, err set, state stays IDLE.

## Test plan
- Reset, then start op=00; res_valid with res=0x12345678_9ABCDEF0 two cycles later -> hi_out=0x12345678, lo_out=0x9ABCDEF0; busy high from the cycle after start through the cycle after res_valid.
- mthi with wdata=0xFFFFFFFF, then mtlo with wdata=0x00000001 in IDLE. Then start op=01 with res=0x00000000_00000001 (HILO_MADD_EN) -> HI:LO=0xFFFFFFFF_00000002, committed 2 cycles after res_valid.
- HI:LO=0, start op=10 with res=1 -> HI:LO wraps to 0xFFFFFFFF_FFFFFFFF, err=0.
- start, then abort and res_valid in the same cycle -> HI/LO unchanged, busy low next cycle, err=0; rd_req during WAIT -> stall=1.
- mthi while busy, and a second start in WAIT -> HI unchanged, err=1 and held; rst asserted mid-WAIT -> all outputs 0 on the next cycle.
- Build without HILO_MADD_EN: start op=01 -> busy stays 0, err=1, HI/LO unchanged.
